// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: request/response front end for the ALU op circuits.
// Latches one op per handshake, runs it through one shared HALF-bit add slice
// (full-word arithmetic takes a low pass and a high pass), owns the {T,C,S,Z}
// status register and holds the result until it is consumed.
// Optional feature: define ALU_OP_SEQUENCER_PERF_EN to add the perf_cnt output.
module alu_op_sequencer #(
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic             req_mode,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_c,
    output logic [WIDTH-1:0] rsp_b,
    output logic             rsp_taken,
    output logic [3:0]       status,
`ifdef ALU_OP_SEQUENCER_PERF_EN
    output logic [15:0]      perf_cnt,
`endif
    input  logic             trap_clr
);

    localparam int unsigned HALF = WIDTH / 2;

    localparam logic [4:0] OpNop = 5'h00, OpTrap = 5'h01, OpJmp = 5'h02, OpJz  = 5'h03;
    localparam logic [4:0] OpJs  = 5'h04, OpJzs  = 5'h05, OpLsr = 5'h06, OpXsr = 5'h07;
    localparam logic [4:0] OpNot = 5'h08, OpAnd  = 5'h09, OpOr  = 5'h0A, OpXor = 5'h0B;
    localparam logic [4:0] OpShr = 5'h0C, OpShl  = 5'h0D, OpRor = 5'h0E, OpRol = 5'h0F;
    localparam logic [4:0] OpSwp = 5'h10, OpInc  = 5'h11, OpDec = 5'h12, OpAdd = 5'h13;
    localparam logic [4:0] OpAdc = 5'h14, OpSub  = 5'h15, OpSbc = 5'h16, OpEq  = 5'h17;
    localparam logic [4:0] OpGt  = 5'h18, OpLt   = 5'h19, OpGe  = 5'h1A, OpLe  = 5'h1B;

    typedef enum logic [2:0] {StIdle, StExec, StExecLo, StExecHi, StResp, StHalt} state_e;

    state_e           state_q, state_d;
    logic [4:0]       op_q;
    logic             mode_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [HALF-1:0]  lo_sum_q;
    logic             lo_carry_q;
    logic [WIDTH-1:0] rsp_c_q, rsp_b_q;
    logic             rsp_taken_q;
    logic [3:0]       status_q;

    logic             accept, two_pass_req, trap_op, is_sub, cin_init, hi_pass;
    logic [WIDTH-1:0] b_eff, mask, a_m, b_m;
    logic [HALF-1:0]  slice_x, slice_y, slice_sum;
    logic             slice_cin, slice_cout;
    logic [WIDTH-1:0] res_c, res_b;
    logic             res_taken, upd_zs, sign_full;
    logic [3:0]       res_status;

    assign req_ready    = (state_q == StIdle);
    assign rsp_valid    = (state_q == StResp);
    assign accept       = req_valid && req_ready;
    assign two_pass_req = req_mode && (req_op >= OpInc) && (req_op <= OpSbc);
    assign trap_op      = (op_q == OpTrap) || (op_q >= 5'h1C);
    assign hi_pass      = (state_q == StExecHi);
    assign rsp_c        = rsp_c_q;
    assign rsp_b        = rsp_b_q;
    assign rsp_taken    = rsp_taken_q;
    assign status       = status_q;

    // Next-state sequencing of the op lifecycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = two_pass_req ? StExecLo : StExec;
            StExec:   state_d = StResp;
            StExecLo: state_d = StExecHi;
            StExecHi: state_d = StResp;
            StResp:   if (rsp_ready) state_d = trap_op ? StHalt : StIdle;
            StHalt:   if (trap_clr) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Shared add slice; subtraction is x + ~y + ~borrow, so borrow = ~carry out.
    always_comb begin
        is_sub = (op_q == OpDec) || (op_q == OpSub) || (op_q == OpSbc);
        b_eff  = ((op_q == OpInc) || (op_q == OpDec)) ? WIDTH'(1) : b_q;
        case (op_q)
            OpAdc:        cin_init = status_q[2];
            OpSub, OpDec: cin_init = 1'b1;
            OpSbc:        cin_init = ~status_q[2];
            default:      cin_init = 1'b0;
        endcase
        slice_x   = hi_pass ? a_q[WIDTH-1:HALF] : a_q[HALF-1:0];
        slice_y   = hi_pass ? b_eff[WIDTH-1:HALF] : b_eff[HALF-1:0];
        slice_y   = is_sub ? ~slice_y : slice_y;
        slice_cin = hi_pass ? lo_carry_q : cin_init;
        {slice_cout, slice_sum} = {1'b0, slice_x} + {1'b0, slice_y} + {{HALF{1'b0}}, slice_cin};
    end

    // Result and status computation for the final execute pass.
    always_comb begin
        res_c      = '0;
        res_b      = '0;
        res_taken  = 1'b0;
        res_status = status_q;
        upd_zs     = 1'b0;
        sign_full  = mode_q;
        mask       = mode_q ? '1 : {{HALF{1'b0}}, {HALF{1'b1}}};
        a_m        = a_q & mask;
        b_m        = b_q & mask;
        case (op_q)
            OpNop: ;
            OpJmp: begin res_c = a_q; res_taken = 1'b1; end
            OpJz:  begin res_c = a_q; res_taken = status_q[0]; end
            OpJs:  begin res_c = a_q; res_taken = status_q[1]; end
            OpJzs: begin res_c = a_q; res_taken = status_q[0] | status_q[1]; end
            OpLsr: res_status[2:0] = a_q[2:0];
            OpXsr: res_status[2:0] = status_q[2:0] ^ a_q[2:0];
            OpNot: begin res_c = ~a_q & mask; upd_zs = 1'b1; end
            OpAnd: begin res_c = a_m & b_m;   upd_zs = 1'b1; end
            OpOr:  begin res_c = a_m | b_m;   upd_zs = 1'b1; end
            OpXor: begin res_c = a_m ^ b_m;   upd_zs = 1'b1; end
            OpShr: begin
                res_c = {1'b0, a_q[WIDTH-1:1]};
                res_status[2] = a_q[0];
                upd_zs = 1'b1;
                sign_full = 1'b1;
            end
            OpShl: begin
                res_c = {a_q[WIDTH-2:0], 1'b0};
                res_status[2] = a_q[WIDTH-1];
                upd_zs = 1'b1;
                sign_full = 1'b1;
            end
            OpRor: res_c = {a_q[0], a_q[WIDTH-1:1]};
            OpRol: res_c = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
            OpSwp: begin res_c = b_q; res_b = a_q; end
            OpInc, OpDec, OpAdd, OpAdc, OpSub, OpSbc: begin
                // In full mode this is the high pass; the low half was saved by the low pass.
                res_c = mode_q ? {slice_sum, lo_sum_q} : {{HALF{1'b0}}, slice_sum};
                res_status[2] = is_sub ? ~slice_cout : slice_cout;
                upd_zs = 1'b1;
            end
            OpEq: begin res_status[0] = (a_m == b_m); res_status[1] = (a_m == b_m); end
            OpGt: begin res_status[0] = (a_m == b_m); res_status[1] = (a_m > b_m);  end
            OpLt: begin res_status[0] = (a_m == b_m); res_status[1] = (a_m < b_m);  end
            OpGe: begin res_status[0] = (a_m == b_m); res_status[1] = (a_m >= b_m); end
            OpLe: begin res_status[0] = (a_m == b_m); res_status[1] = (a_m <= b_m); end
            default: res_status[3] = 1'b1;
        endcase
        if (upd_zs) begin
            res_status[0] = (res_c == '0);
            res_status[1] = sign_full ? res_c[WIDTH-1] : res_c[HALF-1];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Operand capture at accept and low-pass carry chain storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OpNop;
            mode_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            lo_sum_q   <= '0;
            lo_carry_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= req_op;
                mode_q <= req_mode;
                a_q    <= req_a;
                b_q    <= req_b;
            end
            if (state_q == StExecLo) begin
                lo_sum_q   <= slice_sum;
                lo_carry_q <= slice_cout;
            end
        end
    end

    // Response and status registers, loaded on the edge entering RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_c_q     <= '0;
            rsp_b_q     <= '0;
            rsp_taken_q <= 1'b0;
            status_q    <= '0;
        end else if ((state_q == StExec) || (state_q == StExecHi)) begin
            rsp_c_q     <= res_c;
            rsp_b_q     <= res_b;
            rsp_taken_q <= res_taken;
            status_q    <= res_status;
        end else if ((state_q == StHalt) && trap_clr) begin
            status_q[3] <= 1'b0;
        end
    end

`ifdef ALU_OP_SEQUENCER_PERF_EN
    logic [15:0] perf_cnt_q;
    assign perf_cnt = perf_cnt_q;

    // Saturating count of response handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                           perf_cnt_q <= '0;
        else if (rsp_valid && rsp_ready && (perf_cnt_q != 16'hFFFF)) perf_cnt_q <= perf_cnt_q + 16'd1;
    end
`endif

endmodule
